count_wrap_monitor: RTL and testbench
=====================================

// Module: count_wrap_monitor
// PURPOSE
//  Downstream consumer of the mod-(CNT_MAX+1) event counter. Samples each qualified count value,
//  checks it against the expected successor, and detects wrap, skip and stall conditions.
//  Each event is stamped with a free-running time base and queued in a small FIFO.
//  The FIFO drains over a valid/ready interface to the logging and display layer.
// PARAMETERS
//  CNT_W    3   width of the monitored count
//  CNT_MAX  7   terminal count; the upstream counter wraps CNT_MAX -> 0; CNT_MAX < 2**CNT_W
//  TS_W     16  width of the timestamp counter
//  DEPTH    4   event FIFO entries; must be a power of 2, >= 2
// PORTS
//  clock       in   1      single clock; all state changes on its rising edge
//  reset_n     in   1      asynchronous, active-low reset
//  cnt_valid   in   1      cnt_value is sampled on every edge where this is high
//  cnt_value   in   CNT_W  count from the upstream counter
//  clear_stats in   1      one-cycle pulse; clears overflow and wrap_total
//  evt_valid   out  1      FIFO head holds an event
//  evt_ready   in   1      consumer accepts the head on an edge where valid && ready
//  evt_type    out  2      01 WRAP, 10 SKIP, 11 STALL (00 never emitted)
//  evt_count   out  CNT_W  cnt_value that raised the event
//  evt_time    out  TS_W   timestamp at the sampling edge
//  overflow    out  1      sticky: an event was dropped because the FIFO was full
//  wrap_total  out  16     number of WRAP events, saturating
// BEHAVIOUR
//  Reset (async assert, sync release): ts=0, state=INIT, FIFO empty, prev=0.
//   Outputs: evt_valid=0, evt_type/count/time=0, overflow=0, wrap_total=0.
//   Reset mid-operation discards all queued events.
//  ts: increments every clock, wraps at 2**TS_W-1 -> 0. Never gated.
//  FSM, 2 states:
//   INIT : first cnt_valid sample loads prev, emits no event -> TRACK.
//   TRACK: every sample cur is compared with exp = (prev==CNT_MAX) ? 0 : prev+1.
//    - cur==0 && prev==CNT_MAX                    -> WRAP
//    - cur==prev                                  -> STALL
//    - otherwise cur!=exp, including cur>CNT_MAX  -> SKIP
//    - a normal increment emits nothing
//    prev <= cur on every sample, including error samples (resynchronise to the observed value).
//  Event record {type, cur, ts}: compare is combinational against prev; the record is written
//   on the same edge that samples cur.
//  Latency: evt_valid rises one cycle after the sampling edge (registered FIFO count).
//  Handshake:
//   - Head fields stay stable while evt_valid && !evt_ready.
//   - evt_ready while !evt_valid is ignored.
//   - When evt_valid drops, data outputs hold their last value.
//  Full FIFO:
//   - Push without a pop in the same cycle: the event is dropped and overflow is set.
//   - Push with a pop in the same cycle: both complete and occupancy is unchanged.
//  Empty FIFO: a push into an empty FIFO is not visible until the next cycle (no bypass).
//  wrap_total: +1 per WRAP, saturates at 16'hFFFF. Counts WRAPs even when they are dropped.
//  clear_stats has priority: if it coincides with a WRAP or a drop, both stats end at 0.
//   Queued events are not touched.
//  Pointers: log2(DEPTH) bits plus an extra wrap bit for full/empty; wrap naturally.
// STRUCTURE
//  Package count_pkg:
//   - EVT_WRAP, EVT_SKIP, EVT_STALL constants
//   - ST_INIT, ST_TRACK state encodings
//   - evt_rec_t = {type[1:0], count[CNT_W-1:0], time[TS_W-1:0]}
//  Sub-module evt_fifo: synchronous FIFO (DEPTH, WIDTH=2+CNT_W+TS_W) with push, pop, full, empty, head.
//  Top module: ts counter, FSM with prev register, classifier, statistics registers.
// TESTING
//  1 Reset, then cnt_valid every cycle with 0..7,0,1
//    -> single WRAP event: count=0, time = ts at that edge; wrap_total=1.
//  2 Sequence 2,3,5 -> SKIP with count=5; then 6 emits nothing (prev resynchronised to 5).
//  3 Sequence 4,4 -> STALL with count=4; 9 samples with cnt_valid low -> no events.
//  4 evt_ready=0, force 5 events -> 4 queued, overflow=1 after the 5th.
//    Then ready=1 -> 4 pops in order; evt_valid=0 after the last.
//  5 FIFO full while a push and a pop coincide -> occupancy stays 4, overflow stays 0.
//    clear_stats pulse -> overflow=0, wrap_total=0.
//  6 Assert reset_n low mid-stream with 2 events queued
//    -> evt_valid=0 immediately (async); next sample after release emits nothing (INIT).

Source files
------------

// File: rtl/count_pkg.sv
// Shared types for the count wrap monitor: event codes, FSM states and the
// event record layout used at the default widths.
package count_pkg;

    localparam int CNT_W_DEF = 3;
    localparam int TS_W_DEF  = 16;

    typedef enum logic [1:0] {
        EVT_NONE  = 2'b00,
        EVT_WRAP  = 2'b01,
        EVT_SKIP  = 2'b10,
        EVT_STALL = 2'b11
    } evt_type_e;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } state_e;

    typedef struct packed {
        logic [1:0]              etype;
        logic [CNT_W_DEF-1:0]    count;
        logic [TS_W_DEF-1:0]     tstamp;
    } evt_rec_t;

endpackage

// File: rtl/count_wrap_monitor_if.sv
// Event drain interface: valid/ready handshake carrying one event record.
interface count_wrap_monitor_if #(
    parameter int CNT_W = 3,
    parameter int TS_W  = 16
);
    logic             evt_valid;
    logic             evt_ready;
    logic [1:0]       evt_type;
    logic [CNT_W-1:0] evt_count;
    logic [TS_W-1:0]  evt_time;

    modport master (
        output evt_valid, evt_type, evt_count, evt_time,
        input  evt_ready
    );

    modport slave (
        input  evt_valid, evt_type, evt_count, evt_time,
        output evt_ready
    );
endinterface

// File: rtl/evt_fifo.sv
// Synchronous event FIFO with a registered head. The head register holds the
// last presented entry once the FIFO empties, and a push into an empty FIFO
// only becomes visible after the writing edge.
module evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 21
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign head    = head_q;

    // Pointer advance and next head selection (fresh write wins over stale storage)
    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
        head_d   = head_q;
        if (wr_ptr_d != rd_ptr_d) begin
            if (do_push && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
                head_d = push_data;
            end else begin
                head_d = mem_q[rd_ptr_d[AW-1:0]];
            end
        end
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    // Pointer and head registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/count_wrap_monitor.sv
// Count wrap monitor: tracks an upstream mod-(CNT_MAX+1) counter, classifies
// each sample as WRAP / SKIP / STALL, timestamps events into a FIFO and keeps
// overflow and wrap statistics.
module count_wrap_monitor
    import count_pkg::*;
#(
    parameter int CNT_W   = 3,
    parameter int CNT_MAX = 7,
    parameter int TS_W    = 16,
    parameter int DEPTH   = 4
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    cnt_valid,
    input  logic [CNT_W-1:0]        cnt_value,
    input  logic                    clear_stats,
    count_wrap_monitor_if.master    evt,
    output logic                    overflow,
    output logic [15:0]             wrap_total
);
    localparam logic [CNT_W-1:0] MAX_V = CNT_W'(CNT_MAX);
    localparam int               REC_W = 2 + CNT_W + TS_W;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   prev_q, prev_d;
    logic [TS_W-1:0]    ts_q, ts_d;
    logic               overflow_q, overflow_d;
    logic [15:0]        wrap_total_q, wrap_total_d;

    evt_type_e          evt_kind;
    logic [CNT_W-1:0]   exp_cnt;
    logic               push, pop, full, empty;
    logic [REC_W-1:0]   push_rec, head_rec;

    // Classify the current sample against the previous one
    always_comb begin
        exp_cnt  = (prev_q == MAX_V) ? '0 : prev_q + CNT_W'(1);
        evt_kind = EVT_NONE;
        if ((cnt_value == '0) && (prev_q == MAX_V)) begin
            evt_kind = EVT_WRAP;
        end else if (cnt_value == prev_q) begin
            evt_kind = EVT_STALL;
        end else if (cnt_value != exp_cnt) begin
            evt_kind = EVT_SKIP;
        end
    end

    // FSM next state: first sample only seeds prev; later samples may push events
    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        push    = 1'b0;
        if (cnt_valid) begin
            prev_d = cnt_value;
            if (state_q == ST_INIT) begin
                state_d = ST_TRACK;
            end else begin
                push = (evt_kind != EVT_NONE);
            end
        end
    end

    assign push_rec = {evt_kind, cnt_value, ts_q};
    assign pop      = evt.evt_ready && !empty;

    // Statistics and free-running time base; clear_stats overrides same-cycle updates
    always_comb begin
        ts_d         = ts_q + TS_W'(1);
        overflow_d   = overflow_q;
        wrap_total_d = wrap_total_q;
        if (push && full && !pop) begin
            overflow_d = 1'b1;
        end
        if (push && (evt_kind == EVT_WRAP)) begin
            wrap_total_d = sat_inc16(wrap_total_q);
        end
        if (clear_stats) begin
            overflow_d   = 1'b0;
            wrap_total_d = '0;
        end
    end

    // State, time base and statistics registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_INIT;
            prev_q       <= '0;
            ts_q         <= '0;
            overflow_q   <= 1'b0;
            wrap_total_q <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            ts_q         <= ts_d;
            overflow_q   <= overflow_d;
            wrap_total_q <= wrap_total_d;
        end
    end

    evt_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .pop       (pop),
        .push_data (push_rec),
        .full      (full),
        .empty     (empty),
        .head      (head_rec)
    );

    assign evt.evt_valid = !empty;
    assign {evt.evt_type, evt.evt_count, evt.evt_time} = head_rec;
    assign overflow      = overflow_q;
    assign wrap_total    = wrap_total_q;

endmodule

// File: tb/tb_count_wrap_monitor.sv
// Bench for count_wrap_monitor: directed vector table, hand-written corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_count_wrap_monitor;
    import count_pkg::*;

    localparam int CNT_W   = 3;
    localparam int CNT_MAX = 7;
    localparam int TS_W    = 16;
    localparam int DEPTH   = 4;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             cnt_valid = 1'b0;
    logic [CNT_W-1:0] cnt_value = '0;
    logic             clear_stats = 1'b0;
    logic             overflow;
    logic [15:0]      wrap_total;

    count_wrap_monitor_if #(.CNT_W(CNT_W), .TS_W(TS_W)) evt_if ();

    count_wrap_monitor #(
        .CNT_W(CNT_W), .CNT_MAX(CNT_MAX), .TS_W(TS_W), .DEPTH(DEPTH)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .cnt_valid   (cnt_valid),
        .cnt_value   (cnt_value),
        .clear_stats (clear_stats),
        .evt         (evt_if),
        .overflow    (overflow),
        .wrap_total  (wrap_total)
    );

    always #5 clock = ~clock;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    evt_rec_t mq[$];
    evt_rec_t m_head;
    bit       m_init;
    int       m_prev;
    int       m_ts;
    bit       m_ovf;
    int       m_wrap;

    typedef struct {
        bit v; int val; bit rdy; bit clr;
        bit e_vld; int e_type; int e_cnt; int e_time; int e_wrap;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        m_head = '0;
        m_init = 0;
        m_prev = 0;
        m_ts   = 0;
        m_ovf  = 0;
        m_wrap = 0;
    endtask

    // One clock of the reference model, using the inputs currently applied
    task automatic model_step();
        int cur, nxt;
        logic [1:0] t;
        evt_rec_t rec;
        if (evt_if.evt_ready && mq.size() != 0) void'(mq.pop_front());
        if (cnt_valid) begin
            cur = int'(cnt_value);
            if (!m_init) begin
                m_init = 1;
            end else begin
                nxt = (m_prev == CNT_MAX) ? 0 : m_prev + 1;
                t = 2'd0;
                if (cur == 0 && m_prev == CNT_MAX) t = 2'd1;
                else if (cur == m_prev)            t = 2'd3;
                else if (cur != nxt)               t = 2'd2;
                if (t == 2'd1 && m_wrap < 65535) m_wrap++;
                if (t != 2'd0) begin
                    rec.etype  = t;
                    rec.count  = cnt_value;
                    rec.tstamp = TS_W'(m_ts);
                    if (mq.size() < DEPTH) mq.push_back(rec);
                    else m_ovf = 1;
                end
            end
            m_prev = cur;
        end
        if (clear_stats) begin
            m_ovf  = 0;
            m_wrap = 0;
        end
        m_ts = (m_ts + 1) % (1 << TS_W);
        if (mq.size() != 0) m_head = mq[0];
    endtask

    task automatic check_model();
        chk("evt_valid",  32'(evt_if.evt_valid), 32'(mq.size() != 0));
        chk("evt_type",   32'(evt_if.evt_type),  32'(m_head.etype));
        chk("evt_count",  32'(evt_if.evt_count), 32'(m_head.count));
        chk("evt_time",   32'(evt_if.evt_time),  32'(m_head.tstamp));
        chk("overflow",   32'(overflow),         32'(m_ovf));
        chk("wrap_total", 32'(wrap_total),       32'(m_wrap));
    endtask

    task automatic cycle(input bit v, input int val, input bit rdy, input bit clr);
        cnt_valid        = v;
        cnt_value        = val[CNT_W-1:0];
        evt_if.evt_ready = rdy;
        clear_stats      = clr;
        model_step();
        @(posedge clock);
        #1;
        check_model();
    endtask

    task automatic add_vec(input bit v, input int val, input bit rdy, input bit clr,
                           input bit ev, input int et, input int ec, input int etm, input int ew);
        vec_t r;
        r.v = v; r.val = val; r.rdy = rdy; r.clr = clr;
        r.e_vld = ev; r.e_type = et; r.e_cnt = ec; r.e_time = etm; r.e_wrap = ew;
        tbl.push_back(r);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pops, r, val;
        bit v;

        // Directed table: count 0..7,0,1 then 2,3,5,6 then 4,4 then 9 idle samples
        for (int i = 0; i < 8; i++) add_vec(1, i, 1, 0, 0, 0, 0, 0, 0);
        add_vec(1, 0, 1, 0, 1, 1, 0, 8, 1);
        add_vec(1, 1, 1, 0, 0, 1, 0, 8, 1);
        add_vec(1, 2, 1, 0, 0, 1, 0, 8, 1);
        add_vec(1, 3, 1, 0, 0, 1, 0, 8, 1);
        add_vec(1, 5, 1, 0, 1, 2, 5, 12, 1);
        add_vec(1, 6, 1, 0, 0, 2, 5, 12, 1);
        add_vec(1, 4, 1, 0, 1, 2, 4, 14, 1);
        add_vec(1, 4, 1, 0, 1, 3, 4, 15, 1);
        for (int i = 0; i < 9; i++) add_vec(0, 0, 1, 0, 0, 3, 4, 15, 1);

        model_reset();
        evt_if.evt_ready = 1'b0;
        #12;
        chk("rst_valid",    32'(evt_if.evt_valid), 32'd0);
        chk("rst_type",     32'(evt_if.evt_type),  32'd0);
        chk("rst_count",    32'(evt_if.evt_count), 32'd0);
        chk("rst_time",     32'(evt_if.evt_time),  32'd0);
        chk("rst_overflow", 32'(overflow),         32'd0);
        chk("rst_wrap",     32'(wrap_total),       32'd0);
        @(posedge clock);
        #3;
        reset_n = 1'b1;

        foreach (tbl[i]) begin
            cycle(tbl[i].v, tbl[i].val, tbl[i].rdy, tbl[i].clr);
            chk($sformatf("tbl%0d_vld", i),  32'(evt_if.evt_valid), 32'(tbl[i].e_vld));
            chk($sformatf("tbl%0d_type", i), 32'(evt_if.evt_type),  32'(tbl[i].e_type));
            chk($sformatf("tbl%0d_cnt", i),  32'(evt_if.evt_count), 32'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_time", i), 32'(evt_if.evt_time),  32'(tbl[i].e_time));
            chk($sformatf("tbl%0d_wrap", i), 32'(wrap_total),       32'(tbl[i].e_wrap));
        end

        // Five STALLs with the consumer blocked: the fifth is dropped
        for (int i = 0; i < 5; i++) begin
            cycle(1, 4, 0, 0);
            if (i == 3) chk("t4_ovf_before", 32'(overflow), 32'd0);
        end
        chk("t4_ovf_after", 32'(overflow), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("t4_pop_vld",  32'(evt_if.evt_valid), 32'd1);
            chk("t4_pop_type", 32'(evt_if.evt_type),  32'(EVT_STALL));
            cycle(0, 0, 1, 0);
        end
        chk("t4_empty",      32'(evt_if.evt_valid), 32'd0);
        chk("t4_ovf_sticky", 32'(overflow),         32'd1);

        // Clear, refill to full, then push and pop on the same edge
        cycle(0, 0, 0, 1);
        chk("t5_clr_ovf",  32'(overflow),   32'd0);
        chk("t5_clr_wrap", 32'(wrap_total), 32'd0);
        cycle(1, 5, 0, 0);
        cycle(1, 6, 0, 0);
        cycle(1, 7, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
        chk("t5_wrap_one", 32'(wrap_total), 32'd1);
        cycle(1, 0, 1, 0);
        chk("t5_ovf_pushpop", 32'(overflow), 32'd0);
        pops = 0;
        for (int i = 0; i < 8 && evt_if.evt_valid; i++) begin
            pops++;
            cycle(0, 0, 1, 0);
        end
        chk("t5_occupancy", 32'(pops), 32'd4);

        // Full FIFO, then clear_stats coinciding with a dropped WRAP
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
        for (int i = 1; i <= 7; i++) cycle(1, i, 0, 0);
        cycle(1, 0, 0, 1);
        chk("t5_clr_prio_ovf",  32'(overflow),   32'd0);
        chk("t5_clr_prio_wrap", 32'(wrap_total), 32'd0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0);

        // Reset with two events queued
        cycle(1, 5, 0, 0);
        cycle(1, 5, 0, 0);
        chk("t6_queued_vld", 32'(evt_if.evt_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_vld",  32'(evt_if.evt_valid), 32'd0);
        chk("t6_async_type", 32'(evt_if.evt_type),  32'd0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        cycle(1, 3, 1, 0);
        chk("t6_init_noevt", 32'(evt_if.evt_valid), 32'd0);
        cycle(1, 5, 1, 0);
        chk("t6_skip_after", 32'(evt_if.evt_type), 32'(EVT_SKIP));

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 9) < 7);
            r = $urandom_range(0, 9);
            if (r < 6)      val = (m_prev == CNT_MAX) ? 0 : m_prev + 1;
            else if (r < 8) val = m_prev;
            else            val = $urandom_range(0, CNT_MAX);
            cycle(v, val, 1'($urandom_range(0, 1)), ($urandom_range(0, 29) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
